// File: rtl/timer_unit_counter_ext.sv
// timer_unit_counter_ext: loadable up-counter with compare match, optional
// clear-on-match, one-shot stop and an optional tick prescaler.
// Optional feature macro: TIMER_UNIT_COUNTER_PRESCALER_EN (prescaler present).
// Without the macro every enabled, not-done cycle is a tick and
// prescaler_value_i is ignored.
// When mode_oneshot_i and mode_cmp_clr_i are both set, one-shot wins: the
// counter holds on the match.
module timer_unit_counter_ext #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               write_counter_i,
  input  logic [WIDTH-1:0]   counter_value_i,
  input  logic               reset_count_i,
  input  logic               enable_count_i,
  input  logic [WIDTH-1:0]   compare_value_i,
  input  logic               mode_oneshot_i,
  input  logic               mode_cmp_clr_i,
  input  logic [PRESC_W-1:0] prescaler_value_i,
  output logic [WIDTH-1:0]   counter_value_o,
  output logic               target_reached_o,
  output logic               running_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tgt_d;
  logic             term;
  logic             active;
  logic             tick;
  logic             match;

  // Counting is possible only while enabled and not parked by a one-shot.
  assign active = enable_count_i & ~done_q;

`ifdef TIMER_UNIT_COUNTER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;

  assign term = (presc_q == prescaler_value_i);

  // Prescaler: cleared by sync clear/load, wraps to 0 on its terminal count.
  always_comb begin
    presc_d = presc_q;
    if (reset_count_i || write_counter_i) presc_d = '0;
    else if (active) presc_d = term ? '0 : presc_q + PRESC_W'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_d;
  end
`else
  logic unused_presc;
  assign unused_presc = ^prescaler_value_i;
  assign term         = 1'b1;
`endif

  assign tick  = active & term;
  assign match = tick & (cnt_q == compare_value_i);

  // Next counter / done / pulse in priority order: clear, load, tick, hold.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    tgt_d  = 1'b0;
    if (reset_count_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (write_counter_i) begin
      cnt_d  = counter_value_i;
      done_d = 1'b0;
    end else if (match) begin
      tgt_d = 1'b1;
      if (mode_oneshot_i)      done_d = 1'b1;
      else if (mode_cmp_clr_i) cnt_d  = '0;
      else                     cnt_d  = cnt_q + WIDTH'(1);
    end else if (tick) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter, one-shot flag and registered match pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q            <= '0;
      done_q           <= 1'b0;
      target_reached_o <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      done_q           <= done_d;
      target_reached_o <= tgt_d;
    end
  end

  assign counter_value_o = cnt_q;
  assign running_o       = active;

endmodule

// File: tb/tb_timer_unit_counter_ext.sv
// Self-checking bench for timer_unit_counter_ext (WIDTH=32, PRESC_W=8).
// Directed scenarios use hand-derived constants; the random scenario uses a
// behavioural model tracking counter, prescaler and one-shot state.
module tb_timer_unit_counter_ext;
  localparam int WIDTH   = 32;
  localparam int PRESC_W = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               write_counter_i;
  logic [WIDTH-1:0]   counter_value_i;
  logic               reset_count_i;
  logic               enable_count_i;
  logic [WIDTH-1:0]   compare_value_i;
  logic               mode_oneshot_i;
  logic               mode_cmp_clr_i;
  logic [PRESC_W-1:0] prescaler_value_i;
  logic [WIDTH-1:0]   counter_value_o;
  logic               target_reached_o;
  logic               running_o;

  int n_cmp = 0;
  int n_err = 0;

  timer_unit_counter_ext #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .write_counter_i(write_counter_i), .counter_value_i(counter_value_i),
    .reset_count_i(reset_count_i), .enable_count_i(enable_count_i),
    .compare_value_i(compare_value_i), .mode_oneshot_i(mode_oneshot_i),
    .mode_cmp_clr_i(mode_cmp_clr_i), .prescaler_value_i(prescaler_value_i),
    .counter_value_o(counter_value_o), .target_reached_o(target_reached_o),
    .running_o(running_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock: inputs are held across the rising edge, sampling at the falling edge.
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    write_counter_i   = 1'b0;
    counter_value_i   = '0;
    reset_count_i     = 1'b0;
    enable_count_i    = 1'b0;
    compare_value_i   = '0;
    mode_oneshot_i    = 1'b0;
    mode_cmp_clr_i    = 1'b0;
    prescaler_value_i = '0;
  endtask

  task automatic sync_clear();
    reset_count_i = 1'b1;
    cyc();
    reset_count_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    enable_count_i = 1'b1;
    #12;
    n_cmp++;
    if (counter_value_o !== '0 || target_reached_o !== 1'b0 || running_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset: cnt=%h tgt=%b run=%b expected 0/0/1",
               counter_value_o, target_reached_o, running_o);
    end
    enable_count_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    n_cmp++;
    if (counter_value_o !== '0 || running_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: cnt=%h run=%b expected 0/0", counter_value_o, running_o);
    end
  endtask

  // compare=5 with clear-on-match: 0..5,0 and a pulse every 6 cycles.
  task automatic test_cmp_clr();
    idle_inputs();
    sync_clear();
    compare_value_i = 5;
    mode_cmp_clr_i  = 1'b1;
    enable_count_i  = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      n_cmp++;
      if (counter_value_o !== WIDTH'(k % 6) || target_reached_o !== (k % 6 == 0)) begin
        n_err++;
        $display("FAIL cmp_clr k=%0d: cnt=%0d tgt=%b expected %0d/%b",
                 k, counter_value_o, target_reached_o, k % 6, (k % 6 == 0));
      end
    end
    enable_count_i = 1'b0;
  endtask

`ifdef TIMER_UNIT_COUNTER_PRESCALER_EN
  // Prescaler 3: counter advances every 4 enabled cycles, pulse once after cnt=2 tick.
  task automatic test_prescaler();
    idle_inputs();
    sync_clear();
    prescaler_value_i = 3;
    compare_value_i   = 2;
    enable_count_i    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      n_cmp++;
      if (counter_value_o !== WIDTH'(k / 4) || target_reached_o !== (k == 12)) begin
        n_err++;
        $display("FAIL prescaler k=%0d: cnt=%0d tgt=%b expected %0d/%b",
                 k, counter_value_o, target_reached_o, k / 4, (k == 12));
      end
    end
    enable_count_i = 1'b0;
  endtask
`endif

  task automatic test_oneshot();
    idle_inputs();
    sync_clear();
    compare_value_i = 3;
    mode_oneshot_i  = 1'b1;
    enable_count_i  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_cmp++;
      if (counter_value_o !== WIDTH'(k < 3 ? k : 3) || target_reached_o !== (k == 4) ||
          running_o !== (k < 4)) begin
        n_err++;
        $display("FAIL oneshot k=%0d: cnt=%0d tgt=%b run=%b", k,
                 counter_value_o, target_reached_o, running_o);
      end
    end
    write_counter_i = 1'b1;
    counter_value_i = '0;
    cyc();
    write_counter_i = 1'b0;
    n_cmp++;
    if (counter_value_o !== '0 || running_o !== 1'b1 || target_reached_o !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_reload: cnt=%0d run=%b tgt=%b expected 0/1/0",
               counter_value_o, running_o, target_reached_o);
    end
    cyc();
    n_cmp++;
    if (counter_value_o !== WIDTH'(1)) begin
      n_err++;
      $display("FAIL oneshot_resume: cnt=%0d expected 1", counter_value_o);
    end
    enable_count_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = '1;
    exp_seq[1] = '0;
    exp_seq[2] = WIDTH'(1);
    idle_inputs();
    compare_value_i = 32'h10;
    enable_count_i  = 1'b1;
    write_counter_i = 1'b1;
    counter_value_i = 32'hFFFF_FFFE;
    cyc();
    write_counter_i = 1'b0;
    n_cmp++;
    if (counter_value_o !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL wrap_load: cnt=%h expected fffffffe", counter_value_o);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if (counter_value_o !== exp_seq[k] || target_reached_o !== 1'b0) begin
        n_err++;
        $display("FAIL wrap k=%0d: cnt=%h tgt=%b expected %h/0",
                 k, counter_value_o, target_reached_o, exp_seq[k]);
      end
    end
    enable_count_i = 1'b0;
  endtask

  task automatic test_priority();
    idle_inputs();
    write_counter_i = 1'b1;
    counter_value_i = 7;
    cyc();
    compare_value_i = 7;
    enable_count_i  = 1'b1;
    reset_count_i   = 1'b1;
    counter_value_i = 32'h55;
    cyc();
    n_cmp++;
    if (counter_value_o !== '0 || target_reached_o !== 1'b0) begin
      n_err++;
      $display("FAIL prio_clear: cnt=%h tgt=%b expected 0/0", counter_value_o, target_reached_o);
    end
    reset_count_i   = 1'b0;
    enable_count_i  = 1'b0;
    counter_value_i = 7;
    cyc();
    enable_count_i  = 1'b1;
    counter_value_i = 32'h55;
    cyc();
    write_counter_i = 1'b0;
    enable_count_i  = 1'b0;
    n_cmp++;
    if (counter_value_o !== 32'h55 || target_reached_o !== 1'b0) begin
      n_err++;
      $display("FAIL prio_load: cnt=%h tgt=%b expected 55/0", counter_value_o, target_reached_o);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    write_counter_i = 1'b1;
    counter_value_i = 32'h1234;
    cyc();
    write_counter_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (counter_value_o !== '0 || target_reached_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: cnt=%h tgt=%b expected 0/0", counter_value_o, target_reached_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
  endtask

  // Random traffic against a behavioural model of counter/prescaler/one-shot.
  task automatic test_random();
    logic [WIDTH-1:0]   m_cnt;
    logic [PRESC_W-1:0] m_presc;
    bit                 m_done, m_tgt, term, tick, hit;
    idle_inputs();
    sync_clear();
    m_cnt = '0; m_presc = '0; m_done = 0; m_tgt = 0;
    for (int c = 0; c < 3000; c++) begin
      reset_count_i     = ($urandom_range(0, 40) == 0);
      write_counter_i   = ($urandom_range(0, 20) == 0);
      counter_value_i   = ($urandom_range(0, 7) == 0) ? WIDTH'(-$urandom_range(1, 3))
                                                       : WIDTH'($urandom_range(0, 7));
      enable_count_i    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) compare_value_i = WIDTH'($urandom_range(0, 9));
      if ($urandom_range(0, 31) == 0) begin
        mode_oneshot_i = $urandom_range(0, 1);
        mode_cmp_clr_i = mode_oneshot_i ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 63) == 0) prescaler_value_i = PRESC_W'($urandom_range(0, 3));
      @(posedge clk_i);
`ifdef TIMER_UNIT_COUNTER_PRESCALER_EN
      term = (m_presc == prescaler_value_i);
`else
      term = 1;
`endif
      tick = enable_count_i && !m_done && term;
      hit  = tick && (m_cnt == compare_value_i);
      if (reset_count_i) begin
        m_cnt = '0; m_presc = '0; m_done = 0; m_tgt = 0;
      end else if (write_counter_i) begin
        m_cnt = counter_value_i; m_presc = '0; m_done = 0; m_tgt = 0;
      end else begin
        m_tgt = hit;
        if (enable_count_i && !m_done) m_presc = term ? '0 : m_presc + 1'b1;
        if (hit && mode_oneshot_i)      m_done = 1;
        else if (hit && mode_cmp_clr_i) m_cnt = '0;
        else if (tick)                  m_cnt = m_cnt + 1'b1;
      end
      @(negedge clk_i);
      n_cmp++;
      if (counter_value_o !== m_cnt || target_reached_o !== m_tgt ||
          running_o !== (enable_count_i && !m_done)) begin
        n_err++;
        $display("FAIL random c=%0d: cnt=%h tgt=%b run=%b expected %h/%b/%b", c,
                 counter_value_o, target_reached_o, running_o,
                 m_cnt, m_tgt, enable_count_i && !m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cmp_clr();
`ifdef TIMER_UNIT_COUNTER_PRESCALER_EN
    test_prescaler();
`endif
    test_oneshot();
    test_wrap();
    test_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
